// File: rtl/div.sv
// Iterative 32-bit signed/unsigned divider: restoring shift-subtract, one quotient
// bit per clock, result = {remainder, quotient}, handshaked with start/annul.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned WW = 2 * DW + 1;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [WW-1:0]   work, work_nx;
  logic [DW-1:0]   divisor, divisor_nx;
  logic            neg_quot, neg_quot_nx;
  logic            neg_rem, neg_rem_nx;
  logic [2*DW-1:0] result_nx;
  logic            ready_nx;

  // Operand magnitudes and sign-correction flags captured at accept
  logic [DW-1:0] mag1_c, mag2_c;
  logic          neg1_c, neg2_c;

  // Single restoring step: partial remainder shifted left with next dividend bit
  logic [DW+1:0] trial_c;

  // Final quotient/remainder with sign correction
  logic [DW-1:0] quot_c, rem_c, quot_fix_c, rem_fix_c;

  always_comb begin
    neg1_c  = signed_div_i & opdata1_i[DW-1];
    neg2_c  = signed_div_i & opdata2_i[DW-1];
    mag1_c  = neg1_c ? (~opdata1_i) + DW'(1) : opdata1_i;
    mag2_c  = neg2_c ? (~opdata2_i) + DW'(1) : opdata2_i;
    trial_c = {work[WW-1:DW], work[DW-1]} - {2'b00, divisor};
    quot_c     = work[DW-1:0];
    rem_c      = work[2*DW-1:DW];
    quot_fix_c = neg_quot ? (~quot_c) + DW'(1) : quot_c;
    rem_fix_c  = neg_rem ? (~rem_c) + DW'(1) : rem_c;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    work_nx     = work;
    divisor_nx  = divisor;
    neg_quot_nx = neg_quot;
    neg_rem_nx  = neg_rem;
    result_nx   = '0;
    ready_nx    = 1'b0;

    unique case (state)
      FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_nx = BYZERO;
          end else begin
            state_nx    = ON;
            cnt_nx      = '0;
            work_nx     = {{(DW+1){1'b0}}, mag1_c};
            divisor_nx  = mag2_c;
            neg_quot_nx = neg1_c ^ neg2_c;
            neg_rem_nx  = neg1_c;
          end
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_nx = FREE;
        end else begin
          state_nx = END;
          ready_nx = 1'b1;
        end
      end

      ON: begin
        if (annul_i) begin
          state_nx = FREE;
        end else if (cnt == CW'(DW)) begin
          state_nx  = END;
          result_nx = {rem_fix_c, quot_fix_c};
          ready_nx  = 1'b1;
        end else begin
          // trial_c MSB set means the subtraction underflowed: restore (shift only)
          if (trial_c[DW+1]) begin
            work_nx = {work[WW-2:0], 1'b0};
          end else begin
            work_nx = {trial_c[DW:0], work[DW-2:0], 1'b1};
          end
          cnt_nx = cnt + CW'(1);
        end
      end

      END: begin
        if (start_i) begin
          result_nx = result_o;
          ready_nx  = 1'b1;
        end else begin
          state_nx = FREE;
        end
      end

      default: state_nx = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      work     <= work_nx;
      divisor  <= divisor_nx;
      neg_quot <= neg_quot_nx;
      neg_rem  <= neg_rem_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

endmodule
